// File: rtl/seg7_pkg.sv
// Segment patterns for a {g,f,e,d,c,b,a} display, stored active-high.
// Polarity is applied once, at the output register of the scanner.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] apply_polarity(input logic [6:0] pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner: snapshots the digits once per frame
// and lights one digit at a time, with optional leading-zero blanking.
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic DP_OFF = ACTIVE_LOW;

    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic [4*NUM_DIGITS-1:0]  snap;
    logic [NUM_DIGITS-1:0]    dp_snap;
    logic                     tick;
    logic                     last_digit;
    logic [NUM_DIGITS-1:0]    lz_blank;
    logic [3:0]               cur_code;
    logic                     cur_dp;
    logic                     cur_blank;
    logic [6:0]               cur_pattern;
    logic [6:0]               shown_pattern;
    logic [NUM_DIGITS-1:0]    cur_an;

    assign tick       = (cnt == CNT_LAST);
    assign last_digit = (idx == IDX_LAST);

    // While disabled the snapshot tracks the inputs, so the first frame after
    // enable shows what was present on the last disabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            dp_snap    <= '0;
            frame_done <= 1'b0;
        end else if (!enable) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= digits_in;
            dp_snap    <= dp_in;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + CW'(1);
            frame_done <= tick && last_digit;
            if (tick) begin
                idx <= last_digit ? '0 : idx + IW'(1);
                if (last_digit) begin
                    snap    <= digits_in;
                    dp_snap <= dp_in;
                end
            end
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // while every digit above it (and itself) is zero. Digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero  = upper_zero && (snap[4*k +: 4] == 4'd0);
            lz_blank[k] = upper_zero && (k != 0);
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_code  = snap[4*k +: 4];
                cur_dp    = dp_snap[k];
                cur_blank = lz_blank[k];
            end
        end
    end

    bcd_to_7seg u_decode (
        .code    (cur_code),
        .pattern (cur_pattern)
    );

    assign shown_pattern = (blank_lz && cur_blank) ? SEG_BLANK : cur_pattern;
    assign cur_an        = NUM_DIGITS'(1) << idx;

    // Output registers add one cycle of latency, so each digit stays lit for
    // exactly REFRESH_DIV cycles starting one cycle after idx selects it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else if (!enable) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= apply_polarity(shown_pattern, ACTIVE_LOW);
            dp  <= ACTIVE_LOW ? ~cur_dp : cur_dp;
            an  <= ACTIVE_LOW ? ~cur_an : cur_an;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: the driver queues the expected
// digit slots per frame, a negedge monitor pops them as slots appear.
module tb_bcd_display_scanner;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam bit AL    = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] directed_q[$];
    logic [6:0]  seg_tab[16];
    int          checks = 0;
    int          errors = 0;
    int          fd_count = 0;
    int          fd_expected = 0;

    bcd_display_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .ACTIVE_LOW  (AL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Digit k shows nibble k of v; it is a leading zero when v >> 4k is zero.
    function automatic exp_t model(input logic [15:0] v, input logic [3:0] d, input logic blz, input int k);
        exp_t        e;
        logic [15:0] upper;
        logic [6:0]  p;
        upper = v >> (4 * k);
        p     = seg_tab[upper[3:0]];
        if (blz && k != 0 && upper == 16'd0) p = 7'h00;
        e.an  = ~(4'b0001 << k);
        e.seg = ~p;
        e.dp  = ~d[k];
        return e;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic blz, input int n_shown);
        for (int k = 0; k < n_shown; k++) exp_q.push_back(model(v, d, blz, k));
    endtask

    task automatic check_dark();
        check_output("dark_an", an, 4'hF);
        check_output("dark_seg", seg, 7'h7F);
        check_output("dark_dp", dp, 1'b1);
        check_output("dark_frame_done", frame_done, 1'b0);
    endtask

    task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] d, input logic blz, input int n_shown);
        enable    = 1'b0;
        digits_in = v;
        dp_in     = d;
        blank_lz  = blz;
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame(v, d, blz, n_shown);
    endtask

    // One full frame: a junk mid-frame change, then the value that will be
    // snapshotted at the frame boundary (queued for display next frame).
    task automatic run_frame(input logic blz, input bit last);
        int          junk_c;
        logic [15:0] v;
        logic [3:0]  d;
        junk_c = $urandom_range(0, FRAME - 3);
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk); #1;
            if (c == junk_c) begin
                digits_in = 16'($urandom);
                dp_in     = 4'($urandom);
            end
            if (c == FRAME - 2) begin
                if (!last && directed_q.size() > 0) v = directed_q.pop_front();
                else v = 16'($urandom) >> (4 * $urandom_range(0, 4));
                d         = 4'($urandom);
                digits_in = v;
                dp_in     = d;
                if (!last) push_frame(v, d, blz, ND);
            end
            if (c == FRAME - 1 && last) enable = 1'b0;
        end
        fd_expected++;
    endtask

    task automatic run_segment(input logic [15:0] v, input logic [3:0] d, input logic blz, input int n_frames);
        apply_stimulus(v, d, blz, ND);
        for (int f = 0; f < n_frames; f++) run_frame(blz, f == n_frames - 1);
        @(posedge clk); #1;
        check_dark();
    endtask

    // Monitor: a change of lit digit starts a new slot and pops the scoreboard.
    initial begin
        logic [3:0] prev_an;
        int         slot_len;
        bit         have_cur;
        exp_t       cur;
        prev_an  = 4'hF;
        slot_len = 0;
        have_cur = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (an !== 4'hF) begin
                if (an !== prev_an) begin
                    if (prev_an !== 4'hF) check_output("slot_len", slot_len, RD);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("[TB] FAIL scoreboard_underflow: got slot an=%0h, expected none", an);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                    slot_len = 1;
                end else begin
                    slot_len++;
                end
                if (have_cur) begin
                    check_output("an", an, cur.an);
                    check_output("seg", seg, cur.seg);
                    check_output("dp", dp, cur.dp);
                end
            end
            if (frame_done === 1'b1) begin
                fd_count++;
                check_output("frame_done_slot", {an, 4'(slot_len)}, {4'b0111, 4'(RD)});
            end
            prev_an = an;
        end
    end

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        directed_q = '{16'h0050, 16'h0010, 16'h00F0, 16'h0009};
        reset     = 1'b1;
        enable    = 1'b0;
        blank_lz  = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'h0;
        #12;
        check_dark();
        @(posedge clk); #1;
        reset = 1'b0;

        run_segment(16'h1234, 4'h0, 1'b0, 3);
        run_segment(16'h0050, 4'h2, 1'b1, 3);

        // Drop enable while digit 2 is lit: no frame_done, outputs dark next edge.
        apply_stimulus(16'($urandom), 4'($urandom), 1'b1, 3);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
        end
        enable = 1'b0;
        @(posedge clk); #1;
        check_dark();

        run_segment(16'($urandom) >> 4, 4'($urandom), 1'b1, 5);

        // Async reset mid-scan with enable held: snapshot clears, scan restarts.
        apply_stimulus(16'h4321, 4'hF, 1'b1, 2);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1 check_dark();
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        push_frame(16'h0000, 4'h0, 1'b1, ND);
        for (int f = 0; f < 3; f++) run_frame(1'b1, f == 2);
        @(posedge clk); #1;
        check_dark();

        run_segment(16'($urandom), 4'($urandom), 1'b0, 4);

        repeat (3) @(posedge clk);
        #1;
        check_output("frame_done_count", fd_count, fd_expected);
        check_output("scoreboard_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
